pipelined_control_unit: RTL and testbench

- Parametrised successor to the single-cycle control decoder, for the 5-stage RV32 pipeline.
- Decodes op/funct3/funct7 in Decode, then carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. Each stage gets the signals it consumes.
- Resolves branches and jumps in Execute from ALU flags and self-squashes the wrong-path Decode instruction.
- Optional M-extension and CSR/mret decode.

---
 rtl/pipelined_control_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit for the 5-stage RV32 core.
// Decode is combinational; the control bundle then rides the ID/EX, EX/MEM
// and MEM/WB registers. Branches and jumps resolve in Execute, and a taken
// one squashes the wrong-path instruction currently in Decode.
module pipelined_control_unit #(
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1,
  parameter int ALU_CTRL_W = 5    // needs 5 bits when the M ops (16..23) exist
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op_d,
  input  logic [2:0]            funct3_d,
  input  logic [6:0]            funct7_d,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  negative_e,
  input  logic                  borrow_e,
  output logic [2:0]            ImmSrc_d,
  output logic                  illegal_d,
  output logic [ALU_CTRL_W-1:0] ALU_control_e,
  output logic                  AluSrc_e,
  output logic                  Jalr_mux_sel_e,
  output logic                  PcSrc_e,
  output logic                  is_load_e,
  output logic                  Regwrite_m,
  output logic                  Memwrite_m,
  output logic [2:0]            funct3_m,
  output logic                  Regwrite_w,
  output logic [2:0]            ResultSrc_w,
  output logic                  csr_wre_w,
  output logic                  csr_rde_w,
  output logic                  is_mret_w,
  output logic                  illegal_w
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(10);

  typedef struct packed {
    logic                  regwrite;
    logic                  memwrite;
    logic [2:0]            result_src;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  jalr_sel;
    logic                  branch;
    logic                  jump;
    logic [2:0]            funct3;
    logic                  csr_wre;
    logic                  csr_rde;
    logic                  is_mret;
    logic                  illegal;
    logic                  is_load;
  } ctrl_t;

  // ALU_ADD is code 0, so the all-zero bundle is exactly the bubble.
  localparam ctrl_t BUBBLE = '0;

  ctrl_t dec_d;
  logic  dec_bad;
  ctrl_t id_ex_reg;
  logic  br_cond;

  // Register/immediate ALU op from funct3; alt selects SRA over SRL.
  function automatic logic [ALU_CTRL_W-1:0] alu_rr(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_W-1:0] code;
    case (f3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // Immediate format selection depends on the opcode alone.
  always_comb begin
    ImmSrc_d = 3'b000;
    case (op_d)
      OPC_STORE:           ImmSrc_d = 3'b001;
      OPC_BRANCH:          ImmSrc_d = 3'b010;
      OPC_JAL:             ImmSrc_d = 3'b011;
      OPC_LUI, OPC_AUIPC:  ImmSrc_d = 3'b100;
      default:             ImmSrc_d = 3'b000;
    endcase
  end

  // Main decode; any unsupported encoding collapses to a bubble flagged illegal.
  always_comb begin
    dec_d   = BUBBLE;
    dec_bad = 1'b0;
    case (op_d)
      OPC_OP: begin
        dec_d.regwrite = 1'b1;
        if (funct7_d == 7'b0000000)
          dec_d.alu_ctrl = alu_rr(funct3_d, 1'b0);
        else if (funct7_d == 7'b0100000 && funct3_d == 3'b000)
          dec_d.alu_ctrl = ALU_SUB;
        else if (funct7_d == 7'b0100000 && funct3_d == 3'b101)
          dec_d.alu_ctrl = ALU_SRA;
        else if (ENABLE_M && funct7_d == 7'b0000001)
          dec_d.alu_ctrl = ALU_CTRL_W'({2'b10, funct3_d});
        else
          dec_bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d.regwrite = 1'b1;
        dec_d.alu_src  = 1'b1;
        dec_d.alu_ctrl = alu_rr(funct3_d, funct7_d[5]);
      end
      OPC_LOAD: begin
        dec_d.regwrite   = 1'b1;
        dec_d.result_src = 3'b001;
        dec_d.alu_src    = 1'b1;
        dec_d.is_load    = 1'b1;
        dec_bad          = (funct3_d == 3'b011) || (funct3_d[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec_d.memwrite = 1'b1;
        dec_d.alu_src  = 1'b1;
        dec_bad        = funct3_d[2] || (funct3_d[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        dec_d.branch   = 1'b1;
        dec_d.alu_ctrl = ALU_SUB;
        dec_bad        = (funct3_d[2:1] == 2'b01);
      end
      OPC_JAL: begin
        dec_d.jump       = 1'b1;
        dec_d.regwrite   = 1'b1;
        dec_d.result_src = 3'b010;
      end
      OPC_JALR: begin
        dec_d.jump       = 1'b1;
        dec_d.jalr_sel   = 1'b1;
        dec_d.regwrite   = 1'b1;
        dec_d.result_src = 3'b010;
        dec_d.alu_src    = 1'b1;
        dec_bad          = (funct3_d != 3'b000);
      end
      OPC_LUI: begin
        dec_d.regwrite = 1'b1;
        dec_d.alu_src  = 1'b1;
        dec_d.alu_ctrl = ALU_PASSB;
      end
      OPC_AUIPC: begin
        dec_d.regwrite = 1'b1;
        dec_d.alu_src  = 1'b1;
      end
      OPC_SYSTEM: begin
        if (!ENABLE_CSR)
          dec_bad = 1'b1;
        else if (funct3_d == 3'b000) begin
          if (funct7_d == 7'b0011000) dec_d.is_mret = 1'b1;
          else                        dec_bad       = 1'b1;
        end else if (funct3_d == 3'b100)
          dec_bad = 1'b1;
        else begin
          // rs1/uimm is not visible here, so the CSR file gates the write.
          dec_d.regwrite   = 1'b1;
          dec_d.result_src = 3'b100;
          dec_d.csr_rde    = 1'b1;
          dec_d.csr_wre    = 1'b1;
        end
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) begin
      dec_d         = BUBBLE;
      dec_d.illegal = 1'b1;
    end else begin
      dec_d.funct3 = funct3_d;
    end
  end

  assign illegal_d = dec_d.illegal;

  // ID/EX: a flush or a taken redirect replaces the wrong-path instruction with a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   id_ex_reg <= BUBBLE;
    else if (flush_e || PcSrc_e) id_ex_reg <= BUBBLE;
    else                        id_ex_reg <= dec_d;
  end

  assign ALU_control_e  = id_ex_reg.alu_ctrl;
  assign AluSrc_e       = id_ex_reg.alu_src;
  assign Jalr_mux_sel_e = id_ex_reg.jalr_sel;
  assign is_load_e      = id_ex_reg.is_load;

  // Branch condition from the ALU flags of the compare done in Execute.
  always_comb begin
    br_cond = 1'b0;
    case (id_ex_reg.funct3)
      3'b000:  br_cond = zero_e;
      3'b001:  br_cond = !zero_e;
      3'b100:  br_cond = negative_e;
      3'b101:  br_cond = !negative_e;
      3'b110:  br_cond = borrow_e;
      3'b111:  br_cond = !borrow_e;
      default: br_cond = 1'b0;
    endcase
    PcSrc_e = id_ex_reg.jump | (id_ex_reg.branch & br_cond);
  end

  // EX/MEM: always advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Regwrite_m <= 1'b0;
      Memwrite_m <= 1'b0;
      funct3_m   <= 3'b000;
    end else begin
      Regwrite_m <= id_ex_reg.regwrite;
      Memwrite_m <= id_ex_reg.memwrite;
      funct3_m   <= id_ex_reg.funct3;
    end
  end

  // Writeback-only fields travel through EX/MEM here so Writeback sees them one cycle later.
  logic [2:0] result_src_m;
  logic       csr_wre_m, csr_rde_m, is_mret_m, illegal_m;

  // EX/MEM side-band fields consumed only in Writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_src_m <= 3'b000;
      csr_wre_m    <= 1'b0;
      csr_rde_m    <= 1'b0;
      is_mret_m    <= 1'b0;
      illegal_m    <= 1'b0;
    end else begin
      result_src_m <= id_ex_reg.result_src;
      csr_wre_m    <= id_ex_reg.csr_wre;
      csr_rde_m    <= id_ex_reg.csr_rde;
      is_mret_m    <= id_ex_reg.is_mret;
      illegal_m    <= id_ex_reg.illegal;
    end
  end

  // MEM/WB: always advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Regwrite_w  <= 1'b0;
      ResultSrc_w <= 3'b000;
      csr_wre_w   <= 1'b0;
      csr_rde_w   <= 1'b0;
      is_mret_w   <= 1'b0;
      illegal_w   <= 1'b0;
    end else begin
      Regwrite_w  <= Regwrite_m;
      ResultSrc_w <= result_src_m;
      csr_wre_w   <= csr_wre_m;
      csr_rde_w   <= csr_rde_m;
      is_mret_w   <= is_mret_m;
      illegal_w   <= illegal_m;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: a full-featured instance and a minimal
// one (no M, no CSR) share the same stimulus and are checked against a
// mnemonic-level reference model of decode, branch resolution and staging.
module tb_pipelined_control_unit;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] op_d = '0;
  logic [2:0] funct3_d = '0;
  logic [6:0] funct7_d = '0;
  logic flush_e = 1'b0, zero_e = 1'b0, negative_e = 1'b0, borrow_e = 1'b0;

  // Full instance outputs
  logic [2:0] ImmSrc_d;  logic illegal_d;
  logic [4:0] ALU_control_e; logic AluSrc_e, Jalr_mux_sel_e, PcSrc_e, is_load_e;
  logic Regwrite_m, Memwrite_m; logic [2:0] funct3_m;
  logic Regwrite_w; logic [2:0] ResultSrc_w; logic csr_wre_w, csr_rde_w, is_mret_w, illegal_w;
  // Minimal instance outputs
  logic [2:0] ImmSrc_d_b;  logic illegal_d_b;
  logic [3:0] ALU_control_e_b; logic AluSrc_e_b, Jalr_mux_sel_e_b, PcSrc_e_b, is_load_e_b;
  logic Regwrite_m_b, Memwrite_m_b; logic [2:0] funct3_m_b;
  logic Regwrite_w_b; logic [2:0] ResultSrc_w_b; logic csr_wre_w_b, csr_rde_w_b, is_mret_w_b, illegal_w_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .ALU_CTRL_W(5)) u_full (
    .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
    .flush_e(flush_e), .zero_e(zero_e), .negative_e(negative_e), .borrow_e(borrow_e),
    .ImmSrc_d(ImmSrc_d), .illegal_d(illegal_d), .ALU_control_e(ALU_control_e),
    .AluSrc_e(AluSrc_e), .Jalr_mux_sel_e(Jalr_mux_sel_e), .PcSrc_e(PcSrc_e),
    .is_load_e(is_load_e), .Regwrite_m(Regwrite_m), .Memwrite_m(Memwrite_m),
    .funct3_m(funct3_m), .Regwrite_w(Regwrite_w), .ResultSrc_w(ResultSrc_w),
    .csr_wre_w(csr_wre_w), .csr_rde_w(csr_rde_w), .is_mret_w(is_mret_w), .illegal_w(illegal_w));

  pipelined_control_unit #(.ENABLE_M(1'b0), .ENABLE_CSR(1'b0), .ALU_CTRL_W(4)) u_min (
    .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
    .flush_e(flush_e), .zero_e(zero_e), .negative_e(negative_e), .borrow_e(borrow_e),
    .ImmSrc_d(ImmSrc_d_b), .illegal_d(illegal_d_b), .ALU_control_e(ALU_control_e_b),
    .AluSrc_e(AluSrc_e_b), .Jalr_mux_sel_e(Jalr_mux_sel_e_b), .PcSrc_e(PcSrc_e_b),
    .is_load_e(is_load_e_b), .Regwrite_m(Regwrite_m_b), .Memwrite_m(Memwrite_m_b),
    .funct3_m(funct3_m_b), .Regwrite_w(Regwrite_w_b), .ResultSrc_w(ResultSrc_w_b),
    .csr_wre_w(csr_wre_w_b), .csr_rde_w(csr_rde_w_b), .is_mret_w(is_mret_w_b), .illegal_w(illegal_w_b));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic regwrite, memwrite; logic [2:0] result_src; logic alu_src; logic [4:0] alu;
    logic jalr, branch, jump; logic [2:0] f3; logic csr_wre, csr_rde, mret, illegal, load;
  } exp_t;

  // ALU code of each funct3 when no alternate form applies: add sll slt sltu xor srl or and
  int rr_tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};

  exp_t pe0 = '0, pm0 = '0, pw0 = '0;   // full instance: E, M, W contents
  exp_t pe1 = '0, pm1 = '0, pw1 = '0;   // minimal instance

  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input bit m_en, input bit csr_en);
    exp_t r; bit bad;
    r = '0; bad = 0;
    if (op == OP) begin
      r.regwrite = 1;
      if (f7 == 7'b0000000)                  r.alu = 5'(rr_tab[f3]);
      else if (f7 == 7'b0100000 && f3 == 0)  r.alu = 5'd1;
      else if (f7 == 7'b0100000 && f3 == 5)  r.alu = 5'd9;
      else if (f7 == 7'b0000001 && m_en)     r.alu = 5'(16 + int'(f3));
      else bad = 1;
    end else if (op == OP_IMM) begin
      r.regwrite = 1; r.alu_src = 1;
      r.alu = (f3 == 5 && f7[5]) ? 5'd9 : 5'(rr_tab[f3]);
    end else if (op == LOAD) begin
      r.regwrite = 1; r.result_src = 3'd1; r.alu_src = 1; r.load = 1;
      bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    end else if (op == STORE) begin
      r.memwrite = 1; r.alu_src = 1; bad = (f3 > 2);
    end else if (op == BRANCH) begin
      r.branch = 1; r.alu = 5'd1; bad = (f3 == 2 || f3 == 3);
    end else if (op == JAL) begin
      r.jump = 1; r.regwrite = 1; r.result_src = 3'd2;
    end else if (op == JALR) begin
      r.jump = 1; r.jalr = 1; r.regwrite = 1; r.result_src = 3'd2; r.alu_src = 1; bad = (f3 != 0);
    end else if (op == LUI) begin
      r.regwrite = 1; r.alu_src = 1; r.alu = 5'd10;
    end else if (op == AUIPC) begin
      r.regwrite = 1; r.alu_src = 1;
    end else if (op == SYSTEM && csr_en) begin
      if (f3 == 0) begin
        if (f7 == 7'b0011000) r.mret = 1; else bad = 1;
      end else if (f3 == 4) bad = 1;
      else begin
        r.regwrite = 1; r.csr_rde = 1; r.csr_wre = 1; r.result_src = 3'd4;
      end
    end else bad = 1;
    if (bad) begin r = '0; r.illegal = 1; end
    else r.f3 = f3;
    return r;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    if (op == STORE) return 3'd1;
    if (op == BRANCH) return 3'd2;
    if (op == JAL) return 3'd3;
    if (op == LUI || op == AUIPC) return 3'd4;
    return 3'd0;
  endfunction

  // Redirect when a jump or a branch whose relation holds sits in Execute.
  function automatic logic ref_taken(input exp_t e, input logic eq, input logic lt, input logic ltu);
    bit rel;
    case (e.f3)
      3'd0: rel = eq;   3'd1: rel = !eq;
      3'd4: rel = lt;   3'd5: rel = !lt;
      3'd6: rel = ltu;  3'd7: rel = !ltu;
      default: rel = 0;
    endcase
    return e.jump || (e.branch && rel);
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic fl, input logic z, input logic n, input logic b);
    op_d = op; funct3_d = f3; funct7_d = f7;
    flush_e = fl; zero_e = z; negative_e = n; borrow_e = b;
    #1;
  endtask

  // One clock; the model shifts alongside the DUTs.
  task automatic advance();
    exp_t n0, n1;
    if (flush_e || ref_taken(pe0, zero_e, negative_e, borrow_e)) n0 = '0;
    else n0 = ref_decode(op_d, funct3_d, funct7_d, 1, 1);
    if (flush_e || ref_taken(pe1, zero_e, negative_e, borrow_e)) n1 = '0;
    else n1 = ref_decode(op_d, funct3_d, funct7_d, 0, 0);
    @(posedge clk);
    if (!rst) begin
      pe0 = '0; pm0 = '0; pw0 = '0; pe1 = '0; pm1 = '0; pw1 = '0;
    end else begin
      pw0 = pm0; pm0 = pe0; pe0 = n0;
      pw1 = pm1; pm1 = pe1; pe1 = n1;
    end
    @(negedge clk); #1;
  endtask

  // Flush one cycle so Execute holds a bubble before a directed scenario.
  task automatic settle();
    apply(OP, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [6:0] rop;
    @(negedge clk); #1;
    rop = 7'($urandom);
    apply(rop, 3'($urandom), 7'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    vectors++;
    if ({ALU_control_e, AluSrc_e, Jalr_mux_sel_e, PcSrc_e, is_load_e, Regwrite_m, Memwrite_m, funct3_m,
         Regwrite_w, ResultSrc_w, csr_wre_w, csr_rde_w, is_mret_w, illegal_w} !== '0) begin
      miscompares++; $display("FAIL reset_regs_full got nonzero ALU=%0d Rw=%b Rs=%0d", ALU_control_e, Regwrite_w, ResultSrc_w);
    end
    vectors++;
    if ({illegal_d, ImmSrc_d} !== {ref_decode(rop, funct3_d, funct7_d, 1, 1).illegal, ref_imm(rop)}) begin
      miscompares++; $display("FAIL reset_decode got ill=%b imm=%0d exp imm=%0d", illegal_d, ImmSrc_d, ref_imm(rop));
    end
    @(negedge clk); #1;
    rst = 1'b1;
    apply(OP, 3'd0, 7'd0, 0, 0, 0, 0);        advance();
    apply(LOAD, 3'd2, 7'd0, 0, 0, 0, 0);      advance();
    apply(STORE, 3'd2, 7'd0, 0, 0, 0, 0);     advance();
    vectors++;
    if (Regwrite_w !== 1'b1) begin miscompares++; $display("FAIL pre_reset_rw got=%b exp=1", Regwrite_w); end
    // Mid-cycle asynchronous reset discards everything in flight.
    #2; rst = 1'b0; #1;
    pe0 = '0; pm0 = '0; pw0 = '0; pe1 = '0; pm1 = '0; pw1 = '0;
    vectors++;
    if ({AluSrc_e, Regwrite_m, Regwrite_w, ResultSrc_w, PcSrc_e, is_load_e,
         AluSrc_e_b, Regwrite_m_b, Regwrite_w_b, ResultSrc_w_b} !== '0) begin
      miscompares++; $display("FAIL async_reset got AluSrc=%b Rm=%b Rw=%b Rs=%0d exp all 0", AluSrc_e, Regwrite_m, Regwrite_w, ResultSrc_w);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    apply(OP, 3'd0, 7'd0, 0, 0, 0, 0);        advance();
    vectors++;
    if ({ALU_control_e, AluSrc_e} !== 6'd0) begin miscompares++; $display("FAIL add_e got alu=%0d src=%b exp 0/0", ALU_control_e, AluSrc_e); end
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);     advance();
    vectors++;
    if (Regwrite_m !== 1'b1) begin miscompares++; $display("FAIL add_m got Rm=%b exp=1", Regwrite_m); end
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);     advance();
    vectors++;
    if ({Regwrite_w, ResultSrc_w} !== 4'b1_000) begin miscompares++; $display("FAIL add_w got Rw=%b Rs=%0d exp 1/0", Regwrite_w, ResultSrc_w); end
  endtask

  task automatic test_bne_squash();
    settle();
    apply(BRANCH, 3'd1, 7'd0, 0, 0, 0, 0);   advance();
    apply(STORE, 3'd2, 7'd0, 0, 0, 0, 0);    // valid SW sitting in Decode on the wrong path
    vectors++;
    if (PcSrc_e !== 1'b1) begin miscompares++; $display("FAIL bne_taken got=%b exp=1", PcSrc_e); end
    advance();
    vectors++;
    if ({AluSrc_e, PcSrc_e} !== 2'b00) begin miscompares++; $display("FAIL bne_bubble_e got src=%b pc=%b exp 0/0", AluSrc_e, PcSrc_e); end
    apply(OP, 3'd0, 7'd0, 0, 1, 0, 0);       advance();
    vectors++;
    if (Memwrite_m !== 1'b0) begin miscompares++; $display("FAIL bne_memwrite got=%b exp=0", Memwrite_m); end
  endtask

  task automatic test_load_flush();
    settle();
    apply(LOAD, 3'd2, 7'd0, 0, 0, 0, 0);     advance();
    vectors++;
    if (is_load_e !== 1'b1) begin miscompares++; $display("FAIL load_e got=%b exp=1", is_load_e); end
    apply(OP, 3'd0, 7'd0, 1, 0, 0, 0);       advance();
    vectors++;
    if (is_load_e !== 1'b0 || Regwrite_m !== 1'b1) begin
      miscompares++; $display("FAIL flush_bubble got load=%b Rm=%b exp 0/1", is_load_e, Regwrite_m);
    end
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);    advance();
    vectors++;
    if ({Regwrite_w, ResultSrc_w} !== 4'b1_001) begin miscompares++; $display("FAIL load_w got Rw=%b Rs=%0d exp 1/1", Regwrite_w, ResultSrc_w); end
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);    advance();
    vectors++;
    if ({Regwrite_w, ResultSrc_w} !== 4'b0_000) begin miscompares++; $display("FAIL flushed_w got Rw=%b Rs=%0d exp 0/0", Regwrite_w, ResultSrc_w); end
  endtask

  task automatic test_mulhu();
    settle();
    apply(OP, 3'd3, 7'b0000001, 0, 0, 0, 0);
    vectors++;
    if ({illegal_d, illegal_d_b} !== 2'b01) begin miscompares++; $display("FAIL mulhu_illegal_d got full=%b min=%b exp 0/1", illegal_d, illegal_d_b); end
    advance();
    vectors++;
    if (ALU_control_e !== 5'd19) begin miscompares++; $display("FAIL mulhu_alu got=%0d exp=19", ALU_control_e); end
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);    advance();
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);    advance();
    vectors++;
    if ({illegal_w_b, Regwrite_w_b, Regwrite_w, illegal_w} !== 4'b1010) begin
      miscompares++; $display("FAIL mulhu_w got min ill=%b rw=%b full rw=%b ill=%b exp 1/0/1/0", illegal_w_b, Regwrite_w_b, Regwrite_w, illegal_w);
    end
  endtask

  task automatic test_csr_mret();
    settle();
    apply(SYSTEM, 3'd1, 7'd0, 0, 0, 0, 0);           advance();
    apply(SYSTEM, 3'd0, 7'b0011000, 0, 0, 0, 0);     advance();
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);            advance();
    vectors++;
    if ({csr_rde_w, csr_wre_w, Regwrite_w, ResultSrc_w, illegal_w_b} !== 7'b111_100_1) begin
      miscompares++; $display("FAIL csrrw_w got rde=%b wre=%b rw=%b rs=%0d min_ill=%b exp 1/1/1/4/1", csr_rde_w, csr_wre_w, Regwrite_w, ResultSrc_w, illegal_w_b);
    end
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);            advance();
    vectors++;
    if ({is_mret_w, Regwrite_w, csr_wre_w, illegal_w_b} !== 4'b1001) begin
      miscompares++; $display("FAIL mret_w got mret=%b rw=%b wre=%b min_ill=%b exp 1/0/0/1", is_mret_w, Regwrite_w, csr_wre_w, illegal_w_b);
    end
  endtask

  task automatic test_bgeu_jalr();
    settle();
    apply(BRANCH, 3'd7, 7'd0, 0, 0, 0, 0);   advance();
    apply(JALR, 3'd0, 7'd0, 0, 0, 0, 1);
    vectors++;
    if (PcSrc_e !== 1'b0) begin miscompares++; $display("FAIL bgeu_not_taken got=%b exp=0", PcSrc_e); end
    advance();
    apply(JAL, 3'd0, 7'd0, 0, 0, 0, 0);      // second jump is on the wrong path
    vectors++;
    if ({PcSrc_e, Jalr_mux_sel_e} !== 2'b11) begin miscompares++; $display("FAIL jalr_e got pc=%b sel=%b exp 1/1", PcSrc_e, Jalr_mux_sel_e); end
    advance();
    apply(STORE, 3'd0, 7'd0, 0, 0, 0, 0);
    vectors++;
    if (PcSrc_e !== 1'b0) begin miscompares++; $display("FAIL jal_squashed got=%b exp=0", PcSrc_e); end
    advance();
    vectors++;
    if ({Regwrite_w, ResultSrc_w} !== 4'b1_010) begin miscompares++; $display("FAIL jalr_w got Rw=%b Rs=%0d exp 1/2", Regwrite_w, ResultSrc_w); end
  endtask

  task automatic test_taken_and_flush();
    settle();
    apply(BRANCH, 3'd0, 7'd0, 0, 0, 0, 0);   advance();
    apply(OP, 3'd0, 7'd0, 1, 1, 0, 0);
    vectors++;
    if (PcSrc_e !== 1'b1) begin miscompares++; $display("FAIL beq_taken got=%b exp=1", PcSrc_e); end
    advance();
    apply(LOAD, 3'd0, 7'd0, 0, 0, 0, 0);     advance();
    vectors++;
    if ({is_load_e, Regwrite_m} !== 2'b10) begin miscompares++; $display("FAIL single_bubble got load=%b Rm=%b exp 1/0", is_load_e, Regwrite_m); end
  endtask

  task automatic test_random(input int n);
    logic [6:0] ops[10] = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
    logic [6:0] f7s[4] = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0011000};
    for (int i = 0; i < n; i++) begin
      logic [6:0] op, f7;
      logic [11:0] ee0, ee1, ae0, ae1;
      int k;
      k  = $urandom_range(0, 10);
      op = (k == 10) ? 7'($urandom) : ops[k];
      k  = $urandom_range(0, 4);
      f7 = (k == 4) ? 7'($urandom) : f7s[k];
      apply(op, 3'($urandom), f7, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if ({illegal_d, ImmSrc_d, illegal_d_b, ImmSrc_d_b} !==
          {ref_decode(op, funct3_d, f7, 1, 1).illegal, ref_imm(op), ref_decode(op, funct3_d, f7, 0, 0).illegal, ref_imm(op)}) begin
        miscompares++; $display("FAIL rnd_decode i=%0d op=%b f3=%0d got ill=%b/%b imm=%0d", i, op, funct3_d, illegal_d, illegal_d_b, ImmSrc_d);
      end
      ae0 = {3'b0, ALU_control_e, AluSrc_e, Jalr_mux_sel_e, PcSrc_e, is_load_e};
      ee0 = {3'b0, pe0.alu, pe0.alu_src, pe0.jalr, ref_taken(pe0, zero_e, negative_e, borrow_e), pe0.load};
      ae1 = {4'b0, ALU_control_e_b, AluSrc_e_b, Jalr_mux_sel_e_b, PcSrc_e_b, is_load_e_b};
      ee1 = {4'b0, pe1.alu[3:0], pe1.alu_src, pe1.jalr, ref_taken(pe1, zero_e, negative_e, borrow_e), pe1.load};
      vectors++;
      if (ae0 !== ee0) begin miscompares++; $display("FAIL rnd_e_full i=%0d got=%h exp=%h", i, ae0, ee0); end
      vectors++;
      if (ae1 !== ee1) begin miscompares++; $display("FAIL rnd_e_min i=%0d got=%h exp=%h", i, ae1, ee1); end
      vectors++;
      if ({Regwrite_m, Memwrite_m, funct3_m, Regwrite_m_b, Memwrite_m_b, funct3_m_b} !==
          {pm0.regwrite, pm0.memwrite, pm0.f3, pm1.regwrite, pm1.memwrite, pm1.f3}) begin
        miscompares++; $display("FAIL rnd_m i=%0d got rw=%b mw=%b f3=%0d exp rw=%b mw=%b f3=%0d", i, Regwrite_m, Memwrite_m, funct3_m, pm0.regwrite, pm0.memwrite, pm0.f3);
      end
      vectors++;
      if ({Regwrite_w, ResultSrc_w, csr_wre_w, csr_rde_w, is_mret_w, illegal_w} !==
          {pw0.regwrite, pw0.result_src, pw0.csr_wre, pw0.csr_rde, pw0.mret, pw0.illegal}) begin
        miscompares++; $display("FAIL rnd_w_full i=%0d got rw=%b rs=%0d ill=%b exp rw=%b rs=%0d ill=%b", i, Regwrite_w, ResultSrc_w, illegal_w, pw0.regwrite, pw0.result_src, pw0.illegal);
      end
      vectors++;
      if ({Regwrite_w_b, ResultSrc_w_b, csr_wre_w_b, csr_rde_w_b, is_mret_w_b, illegal_w_b} !==
          {pw1.regwrite, pw1.result_src, pw1.csr_wre, pw1.csr_rde, pw1.mret, pw1.illegal}) begin
        miscompares++; $display("FAIL rnd_w_min i=%0d got rw=%b rs=%0d ill=%b exp rw=%b rs=%0d ill=%b", i, Regwrite_w_b, ResultSrc_w_b, illegal_w_b, pw1.regwrite, pw1.result_src, pw1.illegal);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_bne_squash();
    test_load_flush();
    test_mulhu();
    test_csr_mret();
    test_bgeu_jalr();
    test_taken_and_flush();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
